// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-add multiply-accumulate: product = A*B (+ C), one multiplier bit per edge.
// Define SHIFT_ADD_ACC_EN to add the C port and accumulate it; otherwise product = A*B.
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
`ifdef SHIFT_ADD_ACC_EN
  input  logic [N-1:0]   C,
`endif
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           valid
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q;
  logic [CW-1:0]  count_q;
  logic [N-1:0]   mcand_q;
  logic [2*N:0]   acc_q;
  logic [2*N:0]   acc_d;
  logic [2*N:0]   acc_load;
  logic [N:0]     upper_sum;
  logic [2*N-1:0] product_q;
  logic           valid_q;

  // The addend sits in the upper half so the N right shifts bring it down to weight 2^0.
`ifdef SHIFT_ADD_ACC_EN
  assign acc_load = {1'b0, C, B};
`else
  assign acc_load = {1'b0, {N{1'b0}}, B};
`endif

  always_comb begin
    upper_sum = acc_q[2*N:N];
    if (acc_q[0]) begin
      upper_sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, mcand_q};
    end
    acc_d = {upper_sum, acc_q[N-1:0]} >> 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= A;
            acc_q   <= acc_load;
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (count_q == LAST) begin
            // Counter returns to 0 instead of incrementing past N-1.
            count_q   <= '0;
            product_q <= acc_d[2*N-1:0];
            valid_q   <= 1'b1;
            state_q   <= IDLE;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q == RUN);
  assign product = product_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized and directed bench for shift_add_multiplier (N=8 with a cycle model, N=2 exhaustive sweep).
// Works in both builds; the expected result drops C when SHIFT_ADD_ACC_EN is undefined.
module tb_shift_add_multiplier;

`ifdef SHIFT_ADD_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, start2;
  logic [7:0]  A8, B8, C8;
  logic [1:0]  A2, B2, C2;
  logic [15:0] prod8;
  logic [3:0]  prod2;
  logic        busy8, valid8, busy2, valid2;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  shift_add_multiplier #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
`ifdef SHIFT_ADD_ACC_EN
    .C(C8),
`endif
    .product(prod8), .busy(busy8), .valid(valid8)
  );

  shift_add_multiplier #(.N(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2),
`ifdef SHIFT_ADD_ACC_EN
    .C(C2),
`endif
    .product(prod2), .busy(busy2), .valid(valid2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int mac(input int a, input int b, input int c);
    return a * b + (ACC ? c : 0);
  endfunction

  // Cycle model for N=8: a request seen while idle completes N edges later with a one-cycle pulse.
  int          m_rem   = 0;
  logic [15:0] m_prod  = '0;
  logic [15:0] m_pend  = '0;
  logic        m_valid = 1'b0;
  int          m_done  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem   = 0;
      m_prod  = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_prod  = m_pend;
          m_valid = 1'b1;
          m_done++;
        end
      end else if (start8) begin
        m_pend = 16'(mac(int'(A8), int'(B8), int'(C8)));
        m_rem  = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_product", 32'(prod8), 32'(m_prod));
      chk("cyc_busy",    32'(busy8), 32'(m_rem > 0));
      chk("cyc_valid",   32'(valid8), 32'(m_valid));
    end
  end

  // Issue one N=8 operation; 'now' means inputs are applied at the current negedge.
  task automatic op8(input int a, input int b, input int c, input bit now,
                     output int lat, output logic [15:0] res);
    if (!now) @(negedge clk);
    A8 = 8'(a); B8 = 8'(b); C8 = 8'(c); start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!valid8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!valid8) chk("op8_timeout", 32'(lat), 32'(9));
    res = prod8;
  endtask

  task automatic op2(input int a, input int b, input int c, output logic [3:0] res);
    int n;
    @(negedge clk);
    A2 = 2'(a); B2 = 2'(b); C2 = 2'(c); start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (!valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!valid2) chk("op2_timeout", 32'(n), 32'(3));
    res = prod2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_cnt;
    int vcnt;
    logic [15:0] res;
    logic [3:0]  r2;

    start8 = 1'b0; start2 = 1'b0;
    A8 = '0; B8 = '0; C8 = '0; A2 = '0; B2 = '0; C2 = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_product", 32'(prod8), 32'(0));
    chk("reset_busy",    32'(busy8), 32'(0));
    chk("reset_valid",   32'(valid8), 32'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    cmp_on = 1'b1;

    // 1: basic MAC with latency and busy width
    @(negedge clk);
    A8 = 8'd13; B8 = 8'd11; C8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!valid8 && lat < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk("t1_latency", 32'(lat), 32'(9));
    chk("t1_busy_cycles", 32'(busy_cnt), 32'(8));
    chk("t1_product", 32'(prod8), ACC ? 32'd150 : 32'd143);

    // 2: full-scale operands
    op8(255, 255, 255, 1'b0, lat, res);
    chk("t2_product", 32'(res), ACC ? 32'h0000FF00 : 32'h0000FE01);

    // 3: zero multiplicand, then idle hold
    op8(0, 200, 42, 1'b0, lat, res);
    chk("t3_product", 32'(res), ACC ? 32'd42 : 32'd0);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid8) vcnt++;
    end
    chk("t3_hold_product", 32'(prod8), ACC ? 32'd42 : 32'd0);
    chk("t3_hold_valid", 32'(vcnt), 32'(0));

    // 4: start and new operands during RUN are ignored
    @(negedge clk);
    A8 = 8'd100; B8 = 8'd37; C8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    A8 = 8'd1; B8 = 8'd2; C8 = 8'd3; start8 = 1'b1;
    repeat (2) @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!valid8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_product", 32'(prod8), ACC ? 32'd3709 : 32'd3700);

    // 5: start in the valid cycle is accepted
    op8(3, 5, 1, 1'b1, lat, res);
    chk("t5_b2b_latency", 32'(lat), 32'(9));
    chk("t5_product", 32'(res), ACC ? 32'd16 : 32'd15);

    // 6: reset mid-RUN
    @(negedge clk);
    A8 = 8'd77; B8 = 8'd99; C8 = 8'd5; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_product", 32'(prod8), 32'(0));
    chk("t6_busy",    32'(busy8), 32'(0));
    chk("t6_valid",   32'(valid8), 32'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid8) vcnt++;
    end
    chk("t6_no_pulse", 32'(vcnt), 32'(0));

    // Randomized traffic, checked every cycle against the model
    vcnt = m_done;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start8 = ($urandom_range(0, 2) == 0);
      A8 = 8'($urandom);
      B8 = 8'($urandom);
      C8 = 8'($urandom);
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("rand_ops_completed", 32'(m_done - vcnt > 50), 32'(1));

    // 7: N=2 exhaustive sweep
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++) begin
          op2(a, b, c, r2);
          chk($sformatf("n2_%0d_%0d_%0d", a, b, c), 32'(r2), 32'(mac(a, b, c)));
        end

    if (ACC) begin
      for (int x = 0; x < 4; x++)
        for (int y = 1; y < 4; y++) begin
          op2(x / y, y, x % y, r2);
          chk($sformatf("div_x%0d_y%0d", x, y), 32'(r2), 32'(x));
        end
    end

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
